// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED glyph path: FSM states, command
// opcodes and font ROM geometry defaults used by the streamer, font ROM and bus driver.
package oled_pkg;

    localparam int          FONT_CODES = 15;
    localparam logic [63:0] WIDE_MASK  = 64'h0BF0;
    localparam int          ROM_LAT    = 1;

    localparam logic [7:0] OLED_CMD_PAGE = 8'hB0;
    localparam logic [7:0] OLED_CMD_COLH = 8'h10;
    localparam logic [7:0] OLED_CMD_COLL = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD0,
        ST_CMD1,
        ST_CMD2,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_OUT
    } glyph_state_t;

    // Final column index of a row: glyph width minus one, optionally clipped
    // so the row never runs past display column 127.
    function automatic logic [3:0] last_index(input logic wide, input logic [6:0] col,
                                              input logic clip_en);
        logic [7:0] width;
        logic [7:0] room;
        width = wide ? 8'd16 : 8'd8;
        room  = 8'd128 - {1'b0, col};
        if (clip_en && (room < width))
            return 4'(room - 8'd1);
        return 4'(width - 8'd1);
    endfunction

endpackage

// File: rtl/oled_byte_hold.sv
// Single-entry output register for (byte, dc, last) with valid/ready.
// Contents stay frozen while the consumer stalls.
module oled_byte_hold (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_dc,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_dc,
    output logic       out_last
);

    logic       valid_reg;
    logic [9:0] data_reg;

    // Accept a new entry when empty or when the current one leaves this cycle.
    assign in_ready = !valid_reg || out_ready;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= {in_last, in_dc, in_byte};
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_byte  = data_reg[7:0];
    assign out_dc    = data_reg[8];
    assign out_last  = data_reg[9];

endmodule

// File: rtl/oled_glyph_streamer.sv
// Sequences one glyph request into font ROM reads and an OLED command/data byte stream.
// Define OLED_GLYPH_CLIP_EN to drop data columns that would fall past display column 127.
module oled_glyph_streamer
    import oled_pkg::*;
#(
    parameter int          FONT_CODES_P = FONT_CODES,
    parameter logic [63:0] WIDE_MASK_P  = WIDE_MASK,
    parameter int          ROM_LAT_P    = ROM_LAT
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_code,
    input  logic [2:0] req_page,
    input  logic [6:0] req_col,
    output logic [5:0] font_sel,
    output logic       font_row,
    output logic [8:0] index,
    input  logic [7:0] font_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_dc,
    output logic       out_last,
    output logic       busy,
    output logic       err_code
);

`ifdef OLED_GLYPH_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    glyph_state_t state_reg, state_next;
    logic [5:0]   code_reg, code_next;
    logic [2:0]   page_reg, page_next;
    logic [6:0]   col_reg, col_next;
    logic [3:0]   last_idx_reg, last_idx_next;
    logic         row_reg, row_next;
    logic [3:0]   idx_reg, idx_next;
    logic [3:0]   wait_reg, wait_next;
    logic         err_reg, err_next;

    logic         hold_in_valid, hold_in_ready, hold_in_dc, hold_in_last;
    logic [7:0]   hold_in_byte;
    logic         code_ok, rd_phase;
    logic [2:0]   row_page;

    assign code_ok  = (32'(req_code) < FONT_CODES_P);
    assign row_page = page_reg + {2'b00, row_reg};
    assign rd_phase = (state_reg == ST_RD_ADDR) || (state_reg == ST_RD_WAIT) ||
                      (state_reg == ST_RD_OUT);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            code_reg     <= '0;
            page_reg     <= '0;
            col_reg      <= '0;
            last_idx_reg <= '0;
            row_reg      <= 1'b0;
            idx_reg      <= '0;
            wait_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            code_reg     <= code_next;
            page_reg     <= page_next;
            col_reg      <= col_next;
            last_idx_reg <= last_idx_next;
            row_reg      <= row_next;
            idx_reg      <= idx_next;
            wait_reg     <= wait_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        code_next     = code_reg;
        page_next     = page_reg;
        col_next      = col_reg;
        last_idx_next = last_idx_reg;
        row_next      = row_reg;
        idx_next      = idx_reg;
        wait_next     = wait_reg;
        err_next      = 1'b0;
        hold_in_valid = 1'b0;
        hold_in_byte  = '0;
        hold_in_dc    = 1'b0;
        hold_in_last  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    if (code_ok) begin
                        code_next     = req_code;
                        page_next     = req_page;
                        col_next      = req_col;
                        last_idx_next = last_index(WIDE_MASK_P[req_code], req_col, CLIP_EN);
                        row_next      = 1'b0;
                        idx_next      = '0;
                        state_next    = ST_CMD0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_CMD0: begin
                hold_in_valid = 1'b1;
                hold_in_byte  = OLED_CMD_PAGE | {5'd0, row_page};
                if (hold_in_ready) state_next = ST_CMD1;
            end
            ST_CMD1: begin
                hold_in_valid = 1'b1;
                hold_in_byte  = OLED_CMD_COLH | {5'd0, col_reg[6:4]};
                if (hold_in_ready) state_next = ST_CMD2;
            end
            ST_CMD2: begin
                hold_in_valid = 1'b1;
                hold_in_byte  = OLED_CMD_COLL | {4'd0, col_reg[3:0]};
                if (hold_in_ready) begin
                    idx_next   = '0;
                    state_next = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                wait_next  = '0;
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_reg == 4'(ROM_LAT_P - 1)) state_next = ST_RD_OUT;
                else                               wait_next  = wait_reg + 4'd1;
            end
            ST_RD_OUT: begin
                // Address stays on the ROM here, so font_data is stable until taken.
                hold_in_valid = 1'b1;
                hold_in_byte  = font_data;
                hold_in_dc    = 1'b1;
                hold_in_last  = row_reg && (idx_reg == last_idx_reg);
                if (hold_in_ready) begin
                    if (idx_reg == last_idx_reg) begin
                        if (row_reg) begin
                            state_next = ST_IDLE;
                        end else begin
                            row_next   = 1'b1;
                            idx_next   = '0;
                            state_next = ST_CMD0;
                        end
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        state_next = ST_RD_ADDR;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    oled_byte_hold u_hold (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .in_valid  (hold_in_valid),
        .in_ready  (hold_in_ready),
        .in_byte   (hold_in_byte),
        .in_dc     (hold_in_dc),
        .in_last   (hold_in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_dc    (out_dc),
        .out_last  (out_last)
    );

    // The glyph is finished only once its final byte has left the hold register.
    assign busy      = (state_reg != ST_IDLE) || out_valid;
    assign req_ready = (state_reg == ST_IDLE) && !out_valid && !err_reg;
    assign err_code  = err_reg;

    assign font_sel  = rd_phase ? code_reg : 6'd0;
    assign font_row  = rd_phase && row_reg;
    assign index     = rd_phase ? {5'd0, idx_reg} : 9'd0;

endmodule

// File: tb/tb_oled_glyph_streamer.sv
// Bench for oled_glyph_streamer: font ROM model, directed glyph cases and random requests
// checked against a byte-stream model. Honours OLED_GLYPH_CLIP_EN when defined.
module tb_oled_glyph_streamer;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_code;
    logic [2:0] req_page;
    logic [6:0] req_col;
    logic [5:0] font_sel;
    logic       font_row;
    logic [8:0] index;
    logic [7:0] font_data = 8'h00;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_dc;
    logic       out_last;
    logic       busy;
    logic       err_code;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    oled_glyph_streamer dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .req_page  (req_page),
        .req_col   (req_col),
        .font_sel  (font_sel),
        .font_row  (font_row),
        .index     (index),
        .font_data (font_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_dc    (out_dc),
        .out_last  (out_last),
        .busy      (busy),
        .err_code  (err_code)
    );

    function automatic logic [7:0] rom_byte(input logic [5:0] sel, input logic row,
                                            input logic [3:0] idx);
        int h;
        if (sel == 6'd0 && idx < 4'd8) begin
            case ({row, idx[2:0]})
                4'h0: return 8'h08;
                4'h1: return 8'hF8;
                4'h2: return 8'h88;
                4'h3: return 8'h88;
                4'h4: return 8'hE8;
                4'h5: return 8'h08;
                4'h6: return 8'h10;
                4'h8: return 8'h20;
                4'h9: return 8'h3F;
                4'hA: return 8'h20;
                4'hC: return 8'h03;
                default: return 8'h00;
            endcase
        end
        if (sel == 6'd4) begin
            case ({row, idx})
                5'h00: return 8'h10;
                5'h01: return 8'h0C;
                5'h10: return 8'h04;
                5'h11: return 8'h84;
                5'h1F: return 8'h00;
                default: ;
            endcase
        end
        h = int'(sel) * 37 + int'(row) * 91 + int'(idx) * 13 + 5;
        return h[7:0];
    endfunction

    always @(posedge sys_clk) font_data <= rom_byte(font_sel, font_row, index[3:0]);

    function automatic int data_count(input int code, input int col);
        int w;
        w = (code inside {4, 5, 6, 7, 8, 9, 11}) ? 16 : 8;
`ifdef OLED_GLYPH_CLIP_EN
        if (128 - col < w) w = 128 - col;
`endif
        return w;
    endfunction

    task automatic build_expected(input int code, input int page, input int col);
        int n;
        n = data_count(code, col);
        exp_q.delete();
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back({2'b00, 8'hB0 | 8'((page + r) % 8)});
            exp_q.push_back({2'b00, 8'h10 | 8'(col / 16)});
            exp_q.push_back({2'b00, 8'(col % 16)});
            for (int i = 0; i < n; i++)
                exp_q.push_back({(r == 1 && i == n - 1), 1'b1, rom_byte(6'(code), r[0], 4'(i))});
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (!req_ready && cyc < 200) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        check_eq("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic run_glyph(input int code, input int page, input int col, input int stall_pct);
        logic [9:0] got_q[$];
        logic [9:0] held;
        bit   stalled, done;
        int   busy_bad, stall_bad, err_seen;
        logic busy_after, ready_after, valid_after;
        build_expected(code, page, col);
        wait_ready();
        req_valid = 1'b1;
        req_code  = 6'(code);
        req_page  = 3'(page);
        req_col   = 7'(col);
        @(posedge sys_clk); #1;
        stalled = 0; done = 0; busy_bad = 0; stall_bad = 0; err_seen = 0; held = '0;
        busy_after = 1'b1; ready_after = 1'b0; valid_after = 1'b1;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            // Noise on the request port must be ignored while busy.
            req_valid = 1'($urandom_range(0, 1));
            req_code  = 6'($urandom);
            req_page  = 3'($urandom);
            req_col   = 7'($urandom);
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            @(negedge sys_clk);
            if (err_code) err_seen++;
            if (got_q.size() < exp_q.size()) begin
                if (!busy) busy_bad++;
                if (stalled && (!out_valid || {out_last, out_dc, out_byte} != held)) stall_bad++;
                stalled = out_valid && !out_ready;
                held    = {out_last, out_dc, out_byte};
                if (out_valid && out_ready) got_q.push_back(held);
            end else begin
                done        = 1;
                req_valid   = 1'b0;
                busy_after  = busy;
                ready_after = req_ready;
                valid_after = out_valid;
            end
            @(posedge sys_clk); #1;
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("stream_done", 32'(done), 32'd1);
        check_eq("byte_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check_eq($sformatf("byte[%0d]{last,dc,byte}", k), 32'(got_q[k]), 32'(exp_q[k]));
        check_eq("busy_during_glyph", busy_bad, 0);
        check_eq("stable_under_stall", stall_bad, 0);
        check_eq("no_err_pulse", err_seen, 0);
        check_eq("busy_after_last", 32'(busy_after), 32'd0);
        check_eq("ready_after_last", 32'(ready_after), 32'd1);
        check_eq("valid_after_last", 32'(valid_after), 32'd0);
        $display("txn glyph code=%0d page=%0d col=%0d stall=%0d%% bytes=%0d expected=%0d",
                 code, page, col, stall_pct, got_q.size(), exp_q.size());
    endtask

    task automatic run_invalid(input int code);
        int vcount;
        wait_ready();
        req_valid = 1'b1;
        req_code  = 6'(code);
        req_page  = 3'($urandom);
        req_col   = 7'($urandom);
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        @(negedge sys_clk);
        check_eq("err_pulse_high", 32'(err_code), 32'd1);
        check_eq("err_ready_low", 32'(req_ready), 32'd0);
        check_eq("err_busy_low", 32'(busy), 32'd0);
        @(negedge sys_clk);
        check_eq("err_pulse_end", 32'(err_code), 32'd0);
        check_eq("err_ready_back", 32'(req_ready), 32'd1);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid || busy) vcount++;
            @(negedge sys_clk);
        end
        check_eq("err_no_output", vcount, 0);
        @(posedge sys_clk); #1;
        $display("txn invalid code=%0d", code);
    endtask

    task automatic run_reset_abort();
        int seen;
        wait_ready();
        req_valid = 1'b1;
        req_code  = 6'd5;
        req_page  = 3'd1;
        req_col   = 7'd40;
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 200 && seen < 6; c++) begin
            @(negedge sys_clk);
            if (out_valid && out_ready) seen++;
            @(posedge sys_clk); #1;
        end
        check_eq("abort_reached_row0_data", seen, 6);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_font_sel", 32'(font_sel), 32'd0);
        check_eq("abort_font_row", 32'(font_row), 32'd0);
        check_eq("abort_index", 32'(index), 32'd0);
        check_eq("abort_req_ready", 32'(req_ready), 32'd1);
        @(posedge sys_clk); @(posedge sys_clk); #1;
        rst = 1'b0;
        $display("txn reset abort during code 5 after %0d bytes", seen);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_code  = '0;
        req_page  = '0;
        req_col   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        @(negedge sys_clk);
        check_eq("reset_req_ready", 32'(req_ready), 32'd1);
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_err_code", 32'(err_code), 32'd0);
        check_eq("reset_font_sel", 32'(font_sel), 32'd0);
        check_eq("reset_index", 32'(index), 32'd0);
        @(posedge sys_clk); #1;

        run_glyph(0, 2, 10, 0);
        run_glyph(4, 7, 0, 0);
        run_glyph(0, 2, 10, 45);
        run_invalid(20);
        run_glyph(1, 5, 33, 0);
        run_reset_abort();
        run_glyph(5, 1, 40, 0);
        run_glyph(4, 3, 120, 0);
        run_glyph(0, 0, 127, 20);
        run_invalid(15);
        run_glyph(14, 6, 96, 30);
        for (int n = 0; n < 12; n++)
            run_glyph(int'($urandom_range(0, 14)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 127)), int'($urandom_range(0, 60)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
